// File: rtl/oc_pkg.sv
// oc_pkg: shared constants, state encoding and LFSR helper for oc_fifteen_pattern_gen
package oc_pkg;
   localparam int N     = 15;
   localparam int CNT_W = 4;
   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
   localparam logic [3:0] LFSR_SEED = 4'b0001;
   localparam logic [3:0] LFSR_TAPS = 4'b1100;
   function automatic logic [3:0] lfsr_next(input logic [3:0] q);
      return {q[2:0], ^(q & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/oc_fifteen_pattern_gen_if.sv
// oc_fifteen_pattern_gen_if: request/result bundle between pattern generator and its driver
interface oc_fifteen_pattern_gen_if #(
   parameter int N     = oc_pkg::N,
   parameter int CNT_W = oc_pkg::CNT_W
);
   logic             start;
   logic [CNT_W-1:0] count;
   logic             ready;
   logic             busy;
   logic             done;
   logic [N-1:0]     vec;
   logic [CNT_W-1:0] count_q;
   modport master (output start, count, input ready, busy, done, vec, count_q);
   modport slave  (input start, count, output ready, busy, done, vec, count_q);
endinterface

// File: rtl/oc_lfsr4.sv
// oc_lfsr4: 4-bit maximal LFSR (x^4+x^3+1) that steps only when adv is high
module oc_lfsr4
   import oc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       adv,
   output logic [3:0] q
);
   logic [3:0] q_d, q_q;
   // step on request, otherwise hold
   always_comb q_d = adv ? lfsr_next(q_q) : q_q;
   // state register, seeded on reset only so jobs keep walking the sequence
   always_ff @(posedge clk) q_q <= rst ? LFSR_SEED : q_d;
   assign q = q_q;
endmodule

// File: rtl/oc_fifteen_pattern_gen.sv
// oc_fifteen_pattern_gen: builds a 15-bit vector with exactly count ones, one bit per clock; OCG_SCRAMBLE_EN selects LFSR bit placement
module oc_fifteen_pattern_gen
   import oc_pkg::*;
#(
   parameter int N     = oc_pkg::N,
   parameter int CNT_W = oc_pkg::CNT_W
)(
   input logic                    clk,
   input logic                    rst,
   oc_fifteen_pattern_gen_if.slave bus
);
   state_t           state_d, state_q;
   logic [CNT_W-1:0] rem_d, rem_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [N-1:0]     vec_d, vec_q;
   logic [N-1:0]     set_vec;
   logic             ready_q, busy_q, done_q;
`ifdef OCG_SCRAMBLE_EN
   logic [3:0] lfsr;
   logic       set;
   assign set = (state_q == FILL) && (rem_q != '0);
   oc_lfsr4 u_lfsr (.clk(clk), .rst(rst), .adv(set), .q(lfsr));
   assign set_vec = vec_q | (N'(1) << (lfsr - 4'd1));
`else
   assign set_vec = {vec_q[N-2:0], 1'b1};
`endif
   // next-state and datapath: accept, fill one bit per cycle, single done cycle
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = FILL;
            rem_d   = bus.count;
            cnt_d   = bus.count;
            vec_d   = '0;
         end
         FILL: if (rem_q != '0) begin
            vec_d = set_vec;
            rem_d = rem_q - 1'b1;
         end else state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // registers, status outputs decoded from the next state so they are flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         vec_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         ready_q <= state_d == IDLE;
         busy_q  <= state_d == FILL;
         done_q  <= state_d == DONE;
      end
   end
   assign bus.ready   = ready_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.vec     = vec_q;
   assign bus.count_q = cnt_q;
endmodule

// File: tb/tb_oc_fifteen_pattern_gen.sv
// tb_oc_fifteen_pattern_gen: scoreboard bench checking latency, vector contents and request handling
module tb_oc_fifteen_pattern_gen;
   import oc_pkg::*;
   typedef struct {int cnt; int acc;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0, errors = 0, cyc = 0, first_done = 1;
   exp_t sb[$];
   exp_t e;
   always #5 clk = ~clk;
   oc_fifteen_pattern_gen_if bus ();
   oc_fifteen_pattern_gen dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   // monitor: pop one expectation per done pulse
   always @(posedge clk) begin
      #1;
      cyc++;
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) check("spurious_done", 1, 0);
         else begin
            e = sb.pop_front();
            check("latency", cyc - e.acc, e.cnt + 1);
            check("count_q", 32'(bus.count_q), e.cnt);
            check("popcount", $countones(bus.vec), e.cnt);
`ifdef OCG_SCRAMBLE_EN
            if (first_done == 1) check("first_vec", 32'(bus.vec), 32'h0001);
`else
            check("vec", 32'(bus.vec), (32'd1 << e.cnt) - 1);
`endif
            first_done = 0;
         end
      end
   end
   task automatic job(input int c);
      int n = 0;
      @(negedge clk);
      while (bus.ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (bus.ready !== 1'b1) check("ready_timeout", 0, 1);
      bus.start = 1'b1;
      bus.count = CNT_W'(c);
      sb.push_back('{c, cyc + 1});
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", 0, 1);
         sb.delete();
      end
      @(negedge clk);
   endtask
   task automatic check_reset_state(input string tag);
      check({tag, "_ready"}, 32'(bus.ready), 1);
      check({tag, "_busy"}, 32'(bus.busy), 0);
      check({tag, "_done"}, 32'(bus.done), 0);
      check({tag, "_vec"}, 32'(bus.vec), 0);
      check({tag, "_count_q"}, 32'(bus.count_q), 0);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.count = '0;
      repeat (3) @(negedge clk);
      check_reset_state("rst");
      rst = 1'b0;
`ifdef OCG_SCRAMBLE_EN
      job(1);
      for (int c = 0; c < 16; c++) job(c);
      wait_idle();
`else
      job(5);
      wait_idle();
      check("hold5_vec", 32'(bus.vec), 32'h001F);
      check("hold5_ready", 32'(bus.ready), 1);
      job(0);
      wait_idle();
      check("hold0_vec", 32'(bus.vec), 0);
      job(15);
      wait_idle();
      check("hold15_vec", 32'(bus.vec), 32'h7FFF);
      job(7);
      @(negedge clk);
      check("fill_busy", 32'(bus.busy), 1);
      check("fill_ready", 32'(bus.ready), 0);
      bus.start = 1'b1;
      bus.count = 4'd3;
      @(negedge clk);
      bus.start = 1'b0;
      wait_idle();
      repeat (10) @(negedge clk);
      check("ignored_vec", 32'(bus.vec), 32'h007F);
      check("ignored_count_q", 32'(bus.count_q), 7);
      job(9);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("abort");
      repeat (14) @(negedge clk);
      job(2);
      wait_idle();
      check("after_abort_vec", 32'(bus.vec), 32'h0003);
      job(4);
      job(1);
      job(3);
      wait_idle();
      check("b2b_vec", 32'(bus.vec), 32'h0007);
`endif
      check("queue_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
